// File: rtl/card_pkg.sv
// Shared widths, street codes, FSM states and the card payload type for the hold'em dealer.
package card_pkg;

  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned NUM_SLOTS = 7;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned STREET_W  = 3;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned ACT_CNT_W = 4;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [STREET_W-1:0] STREET_IDLE  = 3'd0;
  localparam logic [STREET_W-1:0] STREET_HOLE  = 3'd1;
  localparam logic [STREET_W-1:0] STREET_FLOP  = 3'd2;
  localparam logic [STREET_W-1:0] STREET_TURN  = 3'd3;
  localparam logic [STREET_W-1:0] STREET_RIVER = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_PROBE,
    ST_WAIT,
    ST_FIRE,
    ST_SHOWDOWN
  } deal_state_e;

  typedef struct packed {
    logic [SUIT_W-1:0] suit;
    logic [RANK_W-1:0] rank;
  } card_t;

  // Deck index 0..51 -> rank = idx mod 13, suit = idx / 13, without a divider
  function automatic card_t idx_to_card(input logic [IDX_W-1:0] idx);
    card_t            c;
    logic [IDX_W-1:0] r;
    if (idx >= IDX_W'(3 * NUM_RANKS)) begin
      c.suit = 2'd3;
      r      = idx - IDX_W'(3 * NUM_RANKS);
    end else if (idx >= IDX_W'(2 * NUM_RANKS)) begin
      c.suit = 2'd2;
      r      = idx - IDX_W'(2 * NUM_RANKS);
    end else if (idx >= IDX_W'(NUM_RANKS)) begin
      c.suit = 2'd1;
      r      = idx - IDX_W'(NUM_RANKS);
    end else begin
      c.suit = 2'd0;
      r      = idx;
    end
    c.rank = RANK_W'(r);
    return c;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; a load replaces the step, and a zero seed falls back to SEED.
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= (seed == '0) ? SEED : seed;
    end else begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals one hold'em hand (hole, flop, turn, river) without repeats and strobes the evaluator.
// Build option: CARD_DEALER_FIXED_DECK_EN deals the lowest free indices in order.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED        = 16'hACE1,
  parameter int unsigned       ACT_PULSE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          seed_load,
  input  logic [LFSR_W-1:0]             seed,
  input  logic                          new_hand,
  input  logic                          next_street,
  output logic [RANK_W-1:0]             player_card1_number,
  output logic [RANK_W-1:0]             player_card2_number,
  output logic [RANK_W-1:0]             community_card1_number,
  output logic [RANK_W-1:0]             community_card2_number,
  output logic [RANK_W-1:0]             community_card3_number,
  output logic [RANK_W-1:0]             community_card4_number,
  output logic [RANK_W-1:0]             community_card5_number,
  output logic [SUIT_W*NUM_SLOTS-1:0]   card_suits,
  output logic [NUM_SLOTS-1:0]          card_valid,
  output logic [STREET_W-1:0]           street,
  output logic                          busy,
  output logic                          activate,
  output logic                          error
);

  deal_state_e            state_q, state_d;
  logic [IDX_W-1:0]       cand_q, cand_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [1:0]             remain_q, remain_d;
  logic [STREET_W-1:0]    street_q, street_d;
  card_t                  cards_q [NUM_SLOTS];
  card_t                  cards_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [ACT_CNT_W-1:0]   act_cnt_q, act_cnt_d;
  logic                   busy_q, busy_d;
  logic                   act_q, act_d;
  logic                   err_q, err_d;

  logic [LFSR_W-1:0]      lfsr_value;
  logic [IDX_W-1:0]       pick_cand;
  logic                   lfsr_unused;

  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .seed  (seed),
    .value (lfsr_value)
  );

  // Starting index for the free-card search of the next draw
`ifdef CARD_DEALER_FIXED_DECK_EN
  assign pick_cand   = '0;
  assign lfsr_unused = ^lfsr_value;
`else
  assign pick_cand   = (lfsr_value[IDX_W-1:0] >= IDX_W'(DECK_SIZE))
                     ? lfsr_value[IDX_W-1:0] - IDX_W'(DECK_SIZE)
                     : lfsr_value[IDX_W-1:0];
  assign lfsr_unused = ^lfsr_value[LFSR_W-1:IDX_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      used_q    <= '0;
      slot_q    <= '0;
      remain_q  <= '0;
      street_q  <= STREET_IDLE;
      valid_q   <= '0;
      act_cnt_q <= '0;
      busy_q    <= 1'b0;
      act_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < int'(NUM_SLOTS); k++) cards_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      used_q    <= used_d;
      slot_q    <= slot_d;
      remain_q  <= remain_d;
      street_q  <= street_d;
      valid_q   <= valid_d;
      act_cnt_q <= act_cnt_d;
      busy_q    <= busy_d;
      act_q     <= act_d;
      err_q     <= err_d;
      for (int k = 0; k < int'(NUM_SLOTS); k++) cards_q[k] <= cards_d[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    used_d    = used_q;
    slot_d    = slot_q;
    remain_d  = remain_q;
    street_d  = street_q;
    valid_d   = valid_q;
    act_cnt_d = act_cnt_q;
    act_d     = 1'b0;
    err_d     = 1'b0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) cards_d[k] = cards_q[k];

    case (state_q)
      ST_IDLE, ST_WAIT, ST_SHOWDOWN: begin
        if (new_hand) begin
          used_d   = '0;
          valid_d  = '0;
          slot_d   = '0;
          remain_d = 2'd2;
          street_d = STREET_IDLE;
          state_d  = ST_PICK;
          for (int k = 0; k < int'(NUM_SLOTS); k++) cards_d[k] = '0;
        end else if (next_street) begin
          if (state_q == ST_WAIT) begin
            remain_d = (street_q == STREET_HOLE) ? 2'd3 : 2'd1;
            state_d  = ST_PICK;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_PICK: begin
        err_d   = new_hand | next_street;
        cand_d  = pick_cand;
        state_d = ST_PROBE;
      end

      // Linear probe from the candidate to the next unused card, wrapping at the deck end
      ST_PROBE: begin
        err_d = new_hand | next_street;
        if (used_q[cand_q]) begin
          cand_d = (cand_q == IDX_W'(DECK_SIZE - 1)) ? '0 : cand_q + IDX_W'(1);
        end else begin
          cards_d[slot_q] = idx_to_card(cand_q);
          valid_d[slot_q] = 1'b1;
          used_d[cand_q]  = 1'b1;
          slot_d          = slot_q + SLOT_W'(1);
          if (remain_q != 2'd1) begin
            remain_d = remain_q - 2'd1;
            state_d  = ST_PICK;
          end else begin
            remain_d  = '0;
            street_d  = street_q + STREET_W'(1);
            act_cnt_d = '0;
            state_d   = (street_q == STREET_TURN) ? ST_FIRE : ST_WAIT;
          end
        end
      end

      // Cards are already registered here, so activate rises one cycle after the river card
      ST_FIRE: begin
        err_d = new_hand | next_street;
        if (act_cnt_q < ACT_CNT_W'(ACT_PULSE_CYCLES)) begin
          act_d     = 1'b1;
          act_cnt_d = act_cnt_q + ACT_CNT_W'(1);
        end else begin
          state_d = ST_SHOWDOWN;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PICK) || (state_d == ST_PROBE);
  end

  assign player_card1_number    = cards_q[0].rank;
  assign player_card2_number    = cards_q[1].rank;
  assign community_card1_number = cards_q[2].rank;
  assign community_card2_number = cards_q[3].rank;
  assign community_card3_number = cards_q[4].rank;
  assign community_card4_number = cards_q[5].rank;
  assign community_card5_number = cards_q[6].rank;

  always_comb begin
    card_suits = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) card_suits[SUIT_W*k +: SUIT_W] = cards_q[k].suit;
  end

  assign card_valid = valid_q;
  assign street     = street_q;
  assign busy       = busy_q;
  assign activate   = act_q;
  assign error      = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: transaction-level deal model plus directed literal checks.
module tb_card_dealer;
  import card_pkg::*;

  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam int          ACT   = 1;
`ifdef CARD_DEALER_FIXED_DECK_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam int K_CLR = 0, K_SLOT = 1, K_STREET = 2, K_BUSY = 3, K_ACT = 4, K_ERR = 5;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        seed_load = 1'b0, new_hand = 1'b0, next_street = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [3:0]  p1, p2, c1, c2, c3, c4, c5;
  logic [13:0] card_suits;
  logic [6:0]  card_valid;
  logic [2:0]  street;
  logic        busy, activate, error;

  int checks = 0, errors = 0;

  card_dealer #(.LFSR_SEED(SEED0), .ACT_PULSE_CYCLES(ACT)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .new_hand(new_hand), .next_street(next_street),
    .player_card1_number(p1), .player_card2_number(p2),
    .community_card1_number(c1), .community_card2_number(c2),
    .community_card3_number(c3), .community_card4_number(c4),
    .community_card5_number(c5), .card_suits(card_suits),
    .card_valid(card_valid), .street(street), .busy(busy),
    .activate(activate), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model: a timeline of visible output changes ----------------
  typedef struct { int cyc; int kind; int a; int b; } ev_t;
  ev_t         evq[$];
  int          cyc = 0, busy_end = 0, m_street = 0, m_slot = 0;
  bit          m_used[52];
  logic [15:0] m_lfsr = SEED0;
  logic [3:0]  e_num[7];
  logic [1:0]  e_suit[7];
  logic [6:0]  e_valid = '0;
  logic [2:0]  e_street = '0;
  logic        e_busy = 1'b0, e_act = 1'b0, e_err = 1'b0;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic push(input int c, input int k, input int a, input int b);
    ev_t e;
    e.cyc = c; e.kind = k; e.a = a; e.b = b;
    evq.push_back(e);
  endtask

  task automatic model_reset();
    evq.delete();
    cyc = 0; busy_end = 0; m_street = 0; m_slot = 0; m_lfsr = SEED0;
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    for (int k = 0; k < 7; k++) begin e_num[k] = '0; e_suit[k] = '0; end
    e_valid = '0; e_street = '0; e_busy = 1'b0; e_act = 1'b0; e_err = 1'b0;
  endtask

  // Request accepted while the LFSR shows m_lfsr in cycle c: schedule the whole street
  task automatic deal(input int c, input int ncards, input bit fresh);
    int t, cand;
    logic [15:0] lf;
    t = c + 1;
    if (fresh) begin
      push(t, K_CLR, 0, 0);
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
      m_slot = 0; m_street = 0;
    end
    push(t, K_BUSY, 1, 0);
    lf = lstep(m_lfsr);
    for (int n = 0; n < ncards; n++) begin
      cand = FIXED ? 0 : int'(lf[5:0]) % 52;
      t++; lf = lstep(lf);
      while (m_used[cand]) begin cand = (cand + 1) % 52; t++; lf = lstep(lf); end
      t++; lf = lstep(lf);
      push(t, K_SLOT, m_slot, cand);
      m_used[cand] = 1'b1;
      m_slot++;
    end
    m_street++;
    push(t, K_STREET, m_street, 0);
    push(t, K_BUSY, 0, 0);
    if (m_street == 4) begin
      push(t + 1, K_ACT, 1, 0);
      push(t + 1 + ACT, K_ACT, 0, 0);
      busy_end = t + 1 + ACT;
    end else begin
      busy_end = t;
    end
  endtask

  task automatic apply_events();
    int i = 0;
    while (i < evq.size()) begin
      if (evq[i].cyc <= cyc) begin
        case (evq[i].kind)
          K_CLR: begin
            for (int k = 0; k < 7; k++) begin e_num[k] = '0; e_suit[k] = '0; end
            e_valid = '0; e_street = '0;
          end
          K_SLOT: begin
            e_num[evq[i].a]   = 4'(evq[i].b % 13);
            e_suit[evq[i].a]  = 2'(evq[i].b / 13);
            e_valid[evq[i].a] = 1'b1;
          end
          K_STREET: e_street = 3'(evq[i].a);
          K_BUSY:   e_busy   = evq[i].a[0];
          K_ACT:    e_act    = evq[i].a[0];
          default:  e_err    = 1'b1;
        endcase
        evq.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (new_hand || next_street) begin
        if (cyc < busy_end)                 push(cyc + 1, K_ERR, 1, 0);
        else if (new_hand)                  deal(cyc, 2, 1'b1);
        else if (m_street >= 1 && m_street <= 3) deal(cyc, (m_street == 1) ? 3 : 1, 1'b0);
        else                                push(cyc + 1, K_ERR, 1, 0);
      end
      m_lfsr = seed_load ? ((seed == 16'h0) ? SEED0 : seed) : lstep(m_lfsr);
      cyc++;
      e_err = 1'b0;
      apply_events();
    end
  end

  // ---------------- per-cycle compare and protocol monitors ----------------
  int act_rises = 0, busy_run = 0, busy_max = 0;
  logic act_prev = 1'b0, v6_prev = 1'b0;

  always @(negedge clk) begin
    logic [27:0] dn, en;
    logic [13:0] es;
    dn = {c5, c4, c3, c2, c1, p2, p1};
    for (int k = 0; k < 7; k++) begin en[4*k +: 4] = e_num[k]; es[2*k +: 2] = e_suit[k]; end
    chk("numbers",  32'(dn), 32'(en));
    chk("suits",    32'(card_suits), 32'(es));
    chk("valid",    32'(card_valid), 32'(e_valid));
    chk("street",   32'(street), 32'(e_street));
    chk("busy",     32'(busy), 32'(e_busy));
    chk("activate", 32'(activate), 32'(e_act));
    chk("error",    32'(error), 32'(e_err));
    if (activate && !act_prev) begin
      act_rises++;
      chk("act_after_slot6", 32'(v6_prev), 32'd1);
    end
    if (busy) busy_run++;
    else begin
      if (busy_run > busy_max) busy_max = busy_run;
      busy_run = 0;
    end
    act_prev = activate;
    v6_prev  = card_valid[6];
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ready();
    for (int i = 0; i < 2000 && cyc < busy_end; i++) tick();
    if (cyc < busy_end) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cycle %0d still before %0d", cyc, busy_end);
    end
  endtask

  task automatic pulse_nh();
    new_hand = 1'b1; tick(); new_hand = 1'b0;
  endtask

  task automatic pulse_ns();
    next_street = 1'b1; tick(); next_street = 1'b0;
  endtask

  task automatic full_hand();
    ready(); pulse_nh(); ready();
    repeat (3) begin pulse_ns(); ready(); end
  endtask

  task automatic hand_props();
    logic [3:0] r[7];
    logic [1:0] s[7];
    bit ok = 1'b1;
    r = '{p1, p2, c1, c2, c3, c4, c5};
    for (int k = 0; k < 7; k++) s[k] = card_suits[2*k +: 2];
    if (card_valid != 7'h7F) ok = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (r[k] > 4'd12) ok = 1'b0;
      for (int j = 0; j < k; j++) if (r[j] == r[k] && s[j] == s[k]) ok = 1'b0;
    end
    chk("hand_props", 32'(ok), 32'd1);
  endtask

  initial begin
    int a0;
    // Reset state
    repeat (4) tick();
    chk("rst_valid", 32'(card_valid), 32'd0);
    chk("rst_street", 32'(street), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_act_err", 32'({activate, error}), 32'd0);
    chk("rst_cards", 32'({c5, c4, c3, c2, c1, p2, p1}), 32'd0);
    rst_n = 1'b1;
    tick();

    // next_street in IDLE is ignored with a one-cycle error
    pulse_ns();
    chk("idle_ns_err", 32'(error), 32'd1);
    chk("idle_ns_street", 32'(street), 32'd0);
    tick();
    chk("idle_ns_err_drop", 32'(error), 32'd0);

    // Full hand
    ready(); pulse_nh(); ready();
    chk("hole_valid", 32'(card_valid), 32'h03);
    chk("hole_street", 32'(street), 32'd1);
`ifdef CARD_DEALER_FIXED_DECK_EN
    chk("fx_hole", 32'({p2, p1, card_suits[3:0]}), 32'h100);
`endif
    pulse_ns(); ready(); pulse_ns(); ready();
    a0 = act_rises;
    pulse_ns(); ready();
    chk("river_valid", 32'(card_valid), 32'h7F);
    chk("river_street", 32'(street), 32'd4);
    chk("river_one_act", 32'(act_rises - a0), 32'd1);
`ifdef CARD_DEALER_FIXED_DECK_EN
    chk("fx_board", 32'({c5, c4, c3, c2, c1}), 32'h65432);
    chk("fx_board_suits", 32'(card_suits), 32'd0);
`endif
    hand_props();

    // Redeal from SHOWDOWN
    a0 = act_rises;
    pulse_nh();
    chk("redeal_clear", 32'(card_valid), 32'd0);
    ready();
    chk("redeal_valid", 32'(card_valid), 32'h03);
    chk("redeal_no_act", 32'(act_rises - a0), 32'd0);
`ifdef CARD_DEALER_FIXED_DECK_EN
    chk("fx_redeal", 32'({p2, p1}), 32'h10);
`endif

    // new_hand and next_street together in WAIT: new hand wins, no error
    new_hand = 1'b1; next_street = 1'b1; tick(); new_hand = 1'b0; next_street = 1'b0;
    chk("both_no_err", 32'(error), 32'd0);
    chk("both_cleared", 32'({street, card_valid}), 32'd0);
    ready();
    chk("both_dealt", 32'({street, card_valid}), 32'({3'd1, 7'h03}));

    // next_street while drawing is ignored
    pulse_nh();
    pulse_ns();
    chk("busy_ns_err", 32'(error), 32'd1);
    ready();
    chk("busy_ns_unaffected", 32'({street, card_valid}), 32'({3'd1, 7'h03}));

    // Reset in the middle of the flop draw
    pulse_ns(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_clear", 32'({street, card_valid, busy, activate}), 32'd0);
    chk("midrst_cards", 32'({card_suits, p2, p1}), 32'd0);
    a0 = act_rises;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("midrst_no_act", 32'(act_rises - a0), 32'd0);
    a0 = act_rises;
    full_hand();
    chk("post_rst_act", 32'(act_rises - a0), 32'd1);
    hand_props();

    // Zero seed falls back to LFSR_SEED: first pick sees 16'hE270 -> index 48
    ready();
    seed = 16'h0000; seed_load = 1'b1; tick(); seed_load = 1'b0;
    pulse_nh(); ready();
    chk("zero_seed_p1", 32'({card_suits[1:0], p1}), FIXED ? 32'd0 : 32'({2'd3, 4'd9}));

    // Soak from seed 1: first picks see 16'hB400 and 16'h2D00 -> indices 0 and 1
    ready();
    seed = 16'h0001; seed_load = 1'b1; tick(); seed_load = 1'b0;
    pulse_nh(); ready();
    chk("seed1_hole", 32'({card_suits[3:0], p2, p1}), 32'h010);
    a0 = act_rises;
    repeat (3) begin pulse_ns(); ready(); end
    chk("soak_act", 32'(act_rises - a0), 32'd1);
    hand_props();
    for (int h = 1; h < 1000; h++) begin
      a0 = act_rises;
      full_hand();
      chk("soak_act", 32'(act_rises - a0), 32'd1);
      hand_props();
    end
    chk("busy_run_bound", 32'(busy_max <= 3 * 53), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
